// File: rtl/gpu_fill_cmd_parser.sv
// GP0 fill-rectangle command parser.
// Takes a three-word fill packet from the command FIFO: colour, XY origin,
// then size. It latches the fill registers, fires a one-cycle start pulse to
// the fill engine and holds off further words until the engine reports idle.
//
// Handshake: a word is transferred on a rising edge where i_cmdValid and
// o_cmdReady are both 1. o_cmdReady depends only on the current state, never
// on i_cmdValid. The producer holds i_cmdData stable while i_cmdValid=1 and
// the word has not been transferred.
module gpu_fill_cmd_parser #(
  parameter logic [7:0] FILL_OPCODE = 8'h02
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [31:0]        i_cmdData,
  input  logic               i_cmdValid,
  output logic               o_cmdReady,
  output logic [7:0]         o_RegR0,
  output logic [7:0]         o_RegG0,
  output logic [7:0]         o_RegB0,
  output logic signed [11:0] o_RegX0,
  output logic signed [11:0] o_RegY0,
  output logic [10:0]        o_RegSizeW,
  output logic [9:0]         o_RegSizeH,
  output logic               o_activateFILL,
  input  logic               i_FILLInactiveNextCycle,
  output logic               o_busy,
  output logic               o_badCmd,
  output logic [2:0]         o_dbgState
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_XY    = 3'd1,
    S_GET_SIZE  = 3'd2,
    S_LAUNCH    = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [10:0] w_q, w_d;
  logic [9:0]  h_q, h_d;
  logic        bad_q, bad_d;
  logic        ready;
  logic        xfer;

  // Transfer strobe: ready is purely state-decoded, so this has no loop.
  assign xfer = i_cmdValid & ready;

  // Next-state, register-capture and output decode.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    bad_d   = 1'b0;
    ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (xfer) begin
          if (i_cmdData[31:24] == FILL_OPCODE) begin
            r_d     = i_cmdData[7:0];
            g_d     = i_cmdData[15:8];
            b_d     = i_cmdData[23:16];
            state_d = S_GET_XY;
          end else begin
            // Unknown opcode: drop the word, flag it, stay put.
            bad_d = 1'b1;
          end
        end
      end
      S_GET_XY: begin
        ready = 1'b1;
        if (xfer) begin
          // X is snapped down to a 16-pixel boundary.
          x_d     = {2'b0, i_cmdData[9:4], 4'b0};
          y_d     = {3'b0, i_cmdData[24:16]};
          state_d = S_GET_SIZE;
        end
      end
      S_GET_SIZE: begin
        ready = 1'b1;
        if (xfer) begin
          // Width rounds up to a multiple of 16; 11 bits so 0x3F1..0x3FF reach 0x400.
          w_d     = ({1'b0, i_cmdData[9:0]} + 11'd15) & 11'h7F0;
          h_d     = {1'b0, i_cmdData[24:16]};
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_FILLInactiveNextCycle) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and fill-register storage; reset abandons any packet in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      w_q     <= 11'd0;
      h_q     <= 10'd0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      bad_q   <= bad_d;
    end
  end

  assign o_cmdReady     = ready;
  assign o_RegR0        = r_q;
  assign o_RegG0        = g_q;
  assign o_RegB0        = b_q;
  assign o_RegX0        = x_q;
  assign o_RegY0        = y_q;
  assign o_RegSizeW     = w_q;
  assign o_RegSizeH     = h_q;
  assign o_activateFILL = (state_q == S_LAUNCH);
  assign o_busy         = (state_q != S_IDLE);
  assign o_badCmd       = bad_q;
  assign o_dbgState     = state_q;

endmodule

// File: tb/tb_gpu_fill_cmd_parser.sv
// Bench for gpu_fill_cmd_parser: directed packet table, multi-cycle corner
// sequences and randomized packets checked against an arithmetic model.
module tb_gpu_fill_cmd_parser;

  localparam logic [7:0] FILL_OP = 8'h02;
  localparam int W = 69;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]        cmd_data;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [7:0]         r, g, b;
  logic signed [11:0] x, y;
  logic [10:0]        w;
  logic [9:0]         h;
  logic               act;
  logic               fill_inactive;
  logic               busy;
  logic               bad;
  logic [2:0]         dbg_state;
  logic               eng_inact, man_inact;

  assign fill_inactive = eng_inact | man_inact;

  gpu_fill_cmd_parser #(.FILL_OPCODE(FILL_OP)) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_cmdData              (cmd_data),
    .i_cmdValid             (cmd_valid),
    .o_cmdReady             (cmd_ready),
    .o_RegR0                (r),
    .o_RegG0                (g),
    .o_RegB0                (b),
    .o_RegX0                (x),
    .o_RegY0                (y),
    .o_RegSizeW             (w),
    .o_RegSizeH             (h),
    .o_activateFILL         (act),
    .i_FILLInactiveNextCycle(fill_inactive),
    .o_busy                 (busy),
    .o_badCmd               (bad),
    .o_dbgState             (dbg_state)
  );

  logic [W-1:0] regs_w;
  assign regs_w = {r, g, b, x, y, w, h};

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int act_cnt  = 0;
  int bad_cnt  = 0;
  int xfer_cnt = 0;
  bit engine_auto = 1'b1;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: field extraction by plain arithmetic on the words.
  function automatic logic [W-1:0] model(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    int unsigned rr, gg, bb, xx, yy, ww, hh;
    rr = d0 % 256;
    gg = (d0 / 256) % 256;
    bb = (d0 / 65536) % 256;
    xx = ((d1 / 16) % 64) * 16;
    yy = (d1 / 65536) % 512;
    ww = (((d2 % 1024) + 15) / 16) * 16;
    hh = (d2 / 65536) % 512;
    return {rr[7:0], gg[7:0], bb[7:0], xx[11:0], yy[11:0], ww[10:0], hh[9:0]};
  endfunction

  // Activate monitor: each pulse must match the oldest expected packet.
  always @(negedge clk) begin
    if (!rst && act) begin
      act_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_activate: got pulse with regs %0h expected none", regs_w);
      end else begin
        check("scoreboard_regs", regs_w, exp_q.pop_front());
      end
    end
    if (!rst && bad) bad_cnt++;
  end

  // Transfer counter, sampled with pre-edge values.
  always @(posedge clk) begin
    if (!rst && cmd_valid && cmd_ready) xfer_cnt++;
  end

  // Fill engine model: reports inactive 1..3 cycles after the start pulse.
  initial begin
    eng_inact = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && act && engine_auto) begin
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        eng_inact = 1'b1;
        @(negedge clk);
        eng_inact = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send_word(input logic [31:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_word_timeout: got ready=0 expected ready=1 for word %08h", d);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_busy", busy, 1'b0);
  endtask

  task automatic run_packet(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [W-1:0] expv);
    int a0;
    a0 = act_cnt;
    exp_q.push_back(expv);
    send_word(d0);
    send_word(d1);
    send_word(d2);
    cmd_valid = 1'b0;
    check("latency_activate", act, 1'b1);
    wait_idle();
    check("activate_count_per_packet", act_cnt - a0, 1);
    check("regs_hold_after_fill", regs_w, expv);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] d0, d1, d2;
    logic [7:0]  r, g, b;
    logic [11:0] x, y;
    logic [10:0] w;
    logic [9:0]  h;
  } vec_t;

  vec_t vt[6];

  function automatic logic [W-1:0] pack(input vec_t v);
    return {v.r, v.g, v.b, v.x, v.y, v.w, v.h};
  endfunction

  initial begin
    int a0, b0, x0, nfill, nbad, stuck;
    logic [31:0] d0, d1, d2;
    logic [7:0]  op;

    vt[0] = '{32'h02FF8040, 32'h00200013, 32'h0010000F, 8'h40, 8'h80, 8'hFF, 12'h010, 12'h020, 11'h010, 10'h010};
    vt[1] = '{32'h02123456, 32'h00050100, 32'h01FF03F5, 8'h56, 8'h34, 8'h12, 12'h100, 12'h005, 11'h400, 10'h1FF};
    vt[2] = '{32'h02000001, 32'h00000000, 32'h00000000, 8'h01, 8'h00, 8'h00, 12'h000, 12'h000, 11'h000, 10'h000};
    vt[3] = '{32'h02ABCDEF, 32'hFF1FFFFF, 32'hFE00FFF1, 8'hEF, 8'hCD, 8'hAB, 12'h3F0, 12'h11F, 11'h400, 10'h000};
    vt[4] = '{32'h02000000, 32'h00000000, 32'h00000001, 8'h00, 8'h00, 8'h00, 12'h000, 12'h000, 11'h010, 10'h000};
    vt[5] = '{32'h02010203, 32'h0001000F, 32'h000203F0, 8'h03, 8'h02, 8'h01, 12'h000, 12'h001, 11'h3F0, 10'h002};

    man_inact = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 32'h0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_regs", regs_w, '0);
    check("reset_activate", act, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_badcmd", bad, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1'b1);
    check("state_after_reset", dbg_state, 3'd0);

    // Table-driven packets.
    for (int i = 0; i < 6; i++) begin
      run_packet(vt[i].d0, vt[i].d1, vt[i].d2, pack(vt[i]));
    end

    // Non-fill first word is dropped and flagged once.
    a0 = act_cnt;
    b0 = bad_cnt;
    send_word(32'h28000000);
    cmd_valid = 1'b0;
    check("badcmd_pulse", bad, 1'b1);
    check("badcmd_state_idle", dbg_state, 3'd0);
    check("badcmd_not_busy", busy, 1'b0);
    check("badcmd_no_activate", act, 1'b0);
    @(negedge clk);
    check("badcmd_pulse_ends", bad, 1'b0);
    check("badcmd_count", bad_cnt - b0, 1);
    check("badcmd_no_activate_count", act_cnt - a0, 0);
    run_packet(vt[0].d0, vt[0].d1, vt[0].d2, pack(vt[0]));

    // Second packet offered while the engine is still busy.
    engine_auto = 1'b0;
    exp_q.push_back(pack(vt[0]));
    send_word(vt[0].d0);
    send_word(vt[0].d1);
    send_word(vt[0].d2);
    check("wait_launch_pulse", act, 1'b1);
    exp_q.push_back(pack(vt[4]));
    cmd_valid = 1'b1;
    cmd_data  = vt[4].d0;
    stuck = 0;
    repeat (5) begin
      @(negedge clk);
      if (cmd_ready) stuck = 1;
    end
    check("wait_done_ready_low", stuck, 0);
    check("wait_done_state", dbg_state, 3'd4);
    man_inact = 1'b1;
    check("ready_low_on_inactive_cycle", cmd_ready, 1'b0);
    @(negedge clk);
    man_inact = 1'b0;
    check("ready_high_after_inactive", cmd_ready, 1'b1);
    check("idle_after_inactive", dbg_state, 3'd0);
    engine_auto = 1'b1;
    send_word(vt[4].d0);
    send_word(vt[4].d1);
    send_word(vt[4].d2);
    cmd_valid = 1'b0;
    wait_idle();
    check("second_packet_regs", regs_w, pack(vt[4]));

    // Reset after the XY word discards the packet.
    a0 = act_cnt;
    send_word(32'h02AABBCC);
    send_word(32'h00200013);
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midpkt_reset_regs", regs_w, '0);
    check("midpkt_reset_busy", busy, 1'b0);
    check("midpkt_reset_state", dbg_state, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    check("midpkt_ready_after_release", cmd_ready, 1'b1);
    check("midpkt_no_activate", act_cnt - a0, 0);
    run_packet(vt[5].d0, vt[5].d1, vt[5].d2, pack(vt[5]));

    // Valid toggling every cycle across a packet.
    x0 = xfer_cnt;
    exp_q.push_back(pack(vt[1]));
    d0 = vt[1].d0;
    d1 = vt[1].d1;
    d2 = vt[1].d2;
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1;
      cmd_data  = (k == 0) ? d0 : (k == 1) ? d1 : d2;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_data  = $urandom;
      @(negedge clk);
    end
    wait_idle();
    check("toggle_xfer_count", xfer_cnt - x0, 3);
    check("toggle_regs", regs_w, pack(vt[1]));

    // Randomized packets against the arithmetic model.
    a0 = act_cnt;
    b0 = bad_cnt;
    nfill = 0;
    nbad = 0;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = 8'($urandom_range(0, 255));
        if (op == FILL_OP) op = 8'h03;
        send_word({op, 24'($urandom)});
        nbad++;
      end else begin
        d0 = {FILL_OP, 24'($urandom)};
        d1 = $urandom;
        d2 = $urandom;
        exp_q.push_back(model(d0, d1, d2));
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(0, 2) == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
          end
          send_word((k == 0) ? d0 : (k == 1) ? d1 : d2);
        end
        nfill++;
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    wait_idle();
    @(negedge clk);
    check("random_activate_count", act_cnt - a0, nfill);
    check("random_badcmd_count", bad_cnt - b0, nbad);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
